// File: rtl/fpu_arb_pkg.sv
// Shared definitions for the FP add/subtract core arbiter: FSM state encoding,
// operation select codes and an index-width helper.
package fpu_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Width of an index into n entries, never less than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fpu_rr_picker.sv
// Combinational round-robin picker: searches upward from ptr+1 with wrap and
// returns the first active request as one-hot grant and as an index.
module fpu_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               any_req
);

  int          cand;
  logic [IW-1:0] cidx;
  logic        found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    cidx      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(ptr) + i) % NUM_REQ;
      cidx = IW'(cand);
      if (!found && req[cidx]) begin
        found           = 1'b1;
        grant[cidx]     = 1'b1;
        grant_idx       = cidx;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/fpu_addsub_arbiter.sv
// Round-robin arbiter sharing one FP add/subtract core among NUM_REQ requesters.
// Define FPU_ARB_TIMEOUT_EN to add the WAIT watchdog and the timeout_o port.
module fpu_addsub_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int W           = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [NUM_REQ*W-1:0] op_a_i,
  input  logic [NUM_REQ*W-1:0] op_b_i,
  input  logic [NUM_REQ-1:0]   op_sel_i,
  output logic [NUM_REQ-1:0]   ack_o,
  output logic [W-1:0]         result_o,
  output logic                 ovf_o,
  output logic                 unf_o,
  output logic                 busy_o,
  output logic                 core_beg_o,
  output logic                 core_rst_fsm_o,
  output logic [W-1:0]         core_x_o,
  output logic [W-1:0]         core_y_o,
  output logic                 core_op_o,
  input  logic                 core_ready_i,
  input  logic [W-1:0]         core_result_i,
  input  logic                 core_ovf_i,
  input  logic                 core_unf_i
`ifdef FPU_ARB_TIMEOUT_EN
  ,
  output logic                 timeout_o
`endif
);

  localparam int IW = clog2_min1(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || (W != 32 && W != 64) ||
      TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_cfg_check
    $error("fpu_addsub_arbiter: unsupported parameter set");
  end

  arb_state_e           state_reg, state_next;
  logic [IW-1:0]        ptr_reg, ptr_next;
  logic [IW-1:0]        gidx_reg, gidx_next;
  logic [W-1:0]         x_reg, x_next, y_reg, y_next;
  logic                 op_reg, op_next;
  logic [NUM_REQ-1:0]   ack_reg, ack_next;
  logic                 beg_reg, beg_next, rst_fsm_reg, rst_fsm_next;
  logic [W-1:0]         result_reg, result_next;
  logic                 ovf_reg, ovf_next, unf_reg, unf_next;
  logic                 busy_reg, busy_next;
`ifdef FPU_ARB_TIMEOUT_EN
  logic [15:0]          cnt_reg, cnt_next;
  logic                 timeout_reg, timeout_next;
`endif

  logic [NUM_REQ-1:0]   pick_grant;
  logic [IW-1:0]        pick_idx;
  logic                 any_req;
  logic [W-1:0]         a_slice [NUM_REQ];
  logic [W-1:0]         b_slice [NUM_REQ];
  logic [W-1:0]         sel_x, sel_y;
  logic                 sel_op;

  fpu_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_picker (
    .req       (req_i),
    .ptr       (ptr_reg),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any_req   (any_req)
  );

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign a_slice[gi] = op_a_i[gi*W +: W];
    assign b_slice[gi] = op_b_i[gi*W +: W];
  end

  // One-hot AND-OR mux of the winner's operands.
  always_comb begin
    sel_x  = '0;
    sel_y  = '0;
    sel_op = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel_x  = sel_x  | ({W{pick_grant[k]}} & a_slice[k]);
      sel_y  = sel_y  | ({W{pick_grant[k]}} & b_slice[k]);
      sel_op = sel_op | (pick_grant[k] & op_sel_i[k]);
    end
  end

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    gidx_next    = gidx_reg;
    x_next       = x_reg;
    y_next       = y_reg;
    op_next      = op_reg;
    ack_next     = '0;
    beg_next     = 1'b0;
    rst_fsm_next = 1'b0;
    result_next  = result_reg;
    ovf_next     = ovf_reg;
    unf_next     = unf_reg;
    busy_next    = 1'b0;
`ifdef FPU_ARB_TIMEOUT_EN
    cnt_next     = '0;
    timeout_next = timeout_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (any_req) begin
          x_next     = sel_x;
          y_next     = sel_y;
          op_next    = sel_op ? OP_SUB : OP_ADD;
          gidx_next  = pick_idx;
          ptr_next   = pick_idx;
          beg_next   = 1'b1;
          busy_next  = 1'b1;
          state_next = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        busy_next  = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        busy_next = 1'b1;
        if (core_ready_i) begin
          result_next        = core_result_i;
          ovf_next           = core_ovf_i;
          unf_next           = core_unf_i;
          ack_next[gidx_reg] = 1'b1;
          rst_fsm_next       = 1'b1;
          state_next         = ST_RELEASE;
`ifdef FPU_ARB_TIMEOUT_EN
          timeout_next       = 1'b0;
        end else if (cnt_reg == 16'(TIMEOUT_CYC - 1)) begin
          // Core never answered: release the requester with a zeroed result.
          result_next        = '0;
          ovf_next           = 1'b0;
          unf_next           = 1'b0;
          ack_next[gidx_reg] = 1'b1;
          rst_fsm_next       = 1'b1;
          timeout_next       = 1'b1;
          state_next         = ST_RELEASE;
        end else begin
          cnt_next = cnt_reg + 16'd1;
`endif
        end
      end
      ST_RELEASE: begin
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      ptr_reg     <= IW'(NUM_REQ - 1);
      gidx_reg    <= '0;
      x_reg       <= '0;
      y_reg       <= '0;
      op_reg      <= 1'b0;
      ack_reg     <= '0;
      beg_reg     <= 1'b0;
      rst_fsm_reg <= 1'b0;
      result_reg  <= '0;
      ovf_reg     <= 1'b0;
      unf_reg     <= 1'b0;
      busy_reg    <= 1'b0;
`ifdef FPU_ARB_TIMEOUT_EN
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      gidx_reg    <= gidx_next;
      x_reg       <= x_next;
      y_reg       <= y_next;
      op_reg      <= op_next;
      ack_reg     <= ack_next;
      beg_reg     <= beg_next;
      rst_fsm_reg <= rst_fsm_next;
      result_reg  <= result_next;
      ovf_reg     <= ovf_next;
      unf_reg     <= unf_next;
      busy_reg    <= busy_next;
`ifdef FPU_ARB_TIMEOUT_EN
      cnt_reg     <= cnt_next;
      timeout_reg <= timeout_next;
`endif
    end
  end

  assign ack_o          = ack_reg;
  assign result_o       = result_reg;
  assign ovf_o          = ovf_reg;
  assign unf_o          = unf_reg;
  assign busy_o         = busy_reg;
  assign core_beg_o     = beg_reg;
  assign core_rst_fsm_o = rst_fsm_reg;
  assign core_x_o       = x_reg;
  assign core_y_o       = y_reg;
  assign core_op_o      = op_reg;
`ifdef FPU_ARB_TIMEOUT_EN
  assign timeout_o      = timeout_reg;
`endif

endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// Scoreboard bench for fpu_addsub_arbiter: requester agents and a core model
// drive the DUT; a negedge monitor checks grants, operands, results and timing.
module tb_fpu_addsub_arbiter;
  import fpu_arb_pkg::*;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 20;

  logic           clk, rst;
  logic [N-1:0]   req_v, op_sel_v, ack_o;
  logic [N*W-1:0] op_a_v, op_b_v;
  logic [W-1:0]   result_o, core_x_o, core_y_o, core_result_i;
  logic           ovf_o, unf_o, busy_o, core_beg_o, core_rst_fsm_o, core_op_o;
  logic           core_ready_i, core_ovf_i, core_unf_i;
`ifdef FPU_ARB_TIMEOUT_EN
  logic           timeout_o;
`endif

  fpu_addsub_arbiter #(.NUM_REQ(N), .W(W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req_i(req_v), .op_a_i(op_a_v), .op_b_i(op_b_v),
    .op_sel_i(op_sel_v), .ack_o(ack_o), .result_o(result_o), .ovf_o(ovf_o),
    .unf_o(unf_o), .busy_o(busy_o), .core_beg_o(core_beg_o),
    .core_rst_fsm_o(core_rst_fsm_o), .core_x_o(core_x_o), .core_y_o(core_y_o),
    .core_op_o(core_op_o), .core_ready_i(core_ready_i),
    .core_result_i(core_result_i), .core_ovf_i(core_ovf_i), .core_unf_i(core_unf_i)
`ifdef FPU_ARB_TIMEOUT_EN
    , .timeout_o(timeout_o)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    logic         unf;
    logic         tout;
  } exp_t;

  exp_t exp_q [N][$];
  int   grant_log [$];
  int   tests = 0, fails = 0;
  int   beg_cnt = 0, ack_cnt = 0;
  int   cur_winner = 0;
  int   reissue [N];
  int   rnd_todo [N];
  int   lat_cfg = 1;
  bit   glitch_en = 0, scramble_en = 0, core_stall = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Behavioural core: {ovf, unf, result}; one exact IEEE case for the directed test.
  function automatic logic [W+1:0] core_fn(input logic [W-1:0] x, input logic [W-1:0] y, input logic op);
    logic [W-1:0] r;
    if (x == 32'h3F800000 && y == 32'h40000000 && op == OP_ADD) r = 32'h40400000;
    else r = (op == OP_SUB) ? x - y : x + y;
    return {x[30] & y[30], x[29] & y[29] & ~x[30], r};
  endfunction

  // Spec rule: first active requester after the last winner, wrapping.
  function automatic int rr_pick(input int last, input logic [N-1:0] r);
    for (int i = 1; i <= N; i++)
      if (r[(last + i) % N]) return (last + i) % N;
    return -1;
  endfunction

  // ---------------- core model ----------------
  logic         cm_act, cm_ready;
  int           cm_cnt, cm_lat, lat_pick;
  logic [W+1:0] cm_f;

  assign cm_f          = core_fn(core_x_o, core_y_o, core_op_o);
  assign core_ready_i  = cm_ready | (glitch_en & ~cm_act);
  assign core_result_i = cm_ready ? cm_f[W-1:0] : 32'hDEADBEEF;
  assign core_ovf_i    = cm_ready ? cm_f[W+1] : 1'b1;
  assign core_unf_i    = cm_ready ? cm_f[W] : 1'b1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cm_act <= 1'b0; cm_ready <= 1'b0; cm_cnt <= 0;
    end else if (core_rst_fsm_o) begin
      cm_act <= 1'b0; cm_ready <= 1'b0;
    end else if (core_beg_o) begin
      lat_pick = (lat_cfg == 0) ? int'($urandom_range(1, 6)) : lat_cfg;
      cm_act <= 1'b1; cm_ready <= 1'b0; cm_lat <= lat_pick; cm_cnt <= lat_pick - 1;
    end else if (cm_act && !core_stall) begin
      if (cm_cnt == 0) cm_ready <= 1'b1;
      else cm_cnt <= cm_cnt - 1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [N-1:0]   req_at_edge;
  logic [N*W-1:0] a_at_edge, b_at_edge;
  logic [N-1:0]   sel_at_edge;
  always @(posedge clk) begin
    req_at_edge <= req_v;
    a_at_edge   <= op_a_v;
    b_at_edge   <= op_b_v;
    sel_at_edge <= op_sel_v;
  end

  initial begin
    int last_w, w, cyc, beg_cyc;
    bit in_op;
    logic [W-1:0] lx, ly;
    logic lop;
    logic [N-1:0] exp_ack;
    exp_t e;
    last_w = N - 1; in_op = 0; cyc = 0; beg_cyc = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        last_w = N - 1; in_op = 0;
        continue;
      end
      cyc++;
      if (core_beg_o) begin
        chk("beg_while_busy", in_op, 0);
        w = rr_pick(last_w, req_at_edge);
        chk("grant_has_req", (w >= 0), 1);
        if (w < 0) w = 0;
        chk("core_x", core_x_o, a_at_edge[w*W +: W]);
        chk("core_y", core_y_o, b_at_edge[w*W +: W]);
        chk("core_op", core_op_o, sel_at_edge[w]);
        cur_winner = w; last_w = w; in_op = 1; beg_cyc = cyc;
        lx = core_x_o; ly = core_y_o; lop = core_op_o;
        grant_log.push_back(w);
        beg_cnt++;
      end else if (in_op) begin
        chk("x_stable", {core_x_o, core_y_o, core_op_o}, {lx, ly, lop});
      end
      chk("busy", busy_o, in_op);
      chk("rst_fsm_eq_ack", core_rst_fsm_o, |ack_o);
      if (ack_o != '0) begin
        exp_ack = '0;
        if (in_op) exp_ack[cur_winner] = 1'b1;
        chk("ack_onehot", ack_o, exp_ack);
        if (in_op) begin
          chk("exp_available", (exp_q[cur_winner].size() != 0), 1);
          if (exp_q[cur_winner].size() != 0) begin
            e = exp_q[cur_winner].pop_front();
            chk("result", result_o, e.res);
            chk("ovf", ovf_o, e.ovf);
            chk("unf", unf_o, e.unf);
`ifdef FPU_ARB_TIMEOUT_EN
            chk("timeout_o", timeout_o, e.tout);
`endif
            chk("ack_latency", cyc - beg_cyc, e.tout ? TO + 1 : cm_lat + 2);
            $display("[TB] ack req=%0d x=%h y=%h op=%0d res=%h ovf=%0d unf=%0d",
                     cur_winner, lx, ly, lop, result_o, ovf_o, unf_o);
          end
        end
        in_op = 0;
        ack_cnt++;
      end
    end
  end

  // ---------------- requester agents ----------------
  task automatic issue(input int k, input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    logic [W+1:0] f;
    exp_t e;
    op_a_v[k*W +: W] = a;
    op_b_v[k*W +: W] = b;
    op_sel_v[k]      = op;
    f = core_fn(a, b, op);
    if (core_stall) e = '{res: '0, ovf: 1'b0, unf: 1'b0, tout: 1'b1};
    else            e = '{res: f[W-1:0], ovf: f[W+1], unf: f[W], tout: 1'b0};
    exp_q[k].push_back(e);
    req_v[k] = 1'b1;
  endtask

  task automatic issue_rand(input int k);
    issue(k, $urandom, $urandom, 1'($urandom_range(0, 1)));
  endtask

  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      if (ack_o[k] && req_v[k]) begin
        if (reissue[k] > 0) begin
          reissue[k]--; issue_rand(k);
        end else if (rnd_todo[k] > 0 && $urandom_range(0, 1) == 1) begin
          rnd_todo[k]--; issue_rand(k);
        end else begin
          req_v[k] = 1'b0;
        end
      end else if (req_v[k] && scramble_en && busy_o && !core_beg_o && cur_winner == k) begin
        op_a_v[k*W +: W] = $urandom;
        op_b_v[k*W +: W] = $urandom;
        op_sel_v[k]      = ~op_sel_v[k];
      end else if (!req_v[k] && rnd_todo[k] > 0 && $urandom_range(0, 3) == 0) begin
        rnd_todo[k]--; issue_rand(k);
      end
    end
  endtask

  function automatic bit pending();
    for (int k = 0; k < N; k++)
      if (exp_q[k].size() != 0 || reissue[k] != 0 || rnd_todo[k] != 0) return 1;
    return 0;
  endfunction

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((pending() || busy_o || req_v != '0) && n < 4000) begin
      tick(); n++;
    end
    chk({"drain_", tag}, (n < 4000), 1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_v = '0;
    for (int k = 0; k < N; k++) begin
      exp_q[k].delete(); reissue[k] = 0; rnd_todo[k] = 0;
    end
    #1;
    chk("reset_outputs_zero", |{ack_o, result_o, ovf_o, unf_o, busy_o, core_beg_o,
                                core_rst_fsm_o, core_x_o, core_y_o, core_op_o}, 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n, b0, a0, pos1;
    rst = 1'b0; req_v = '0; op_a_v = '0; op_b_v = '0; op_sel_v = '0;
    for (int k = 0; k < N; k++) begin reissue[k] = 0; rnd_todo[k] = 0; end
    repeat (3) @(negedge clk);
    chk("reset_state", |{ack_o, result_o, ovf_o, unf_o, busy_o, core_beg_o,
                         core_rst_fsm_o, core_x_o, core_y_o, core_op_o}, 0);
    rst = 1'b1;
    @(negedge clk);

    // Single request with a 10-cycle core.
    lat_cfg = 10; b0 = beg_cnt;
    issue(0, 32'h3F800000, 32'h40000000, OP_ADD);
    n = 0;
    do begin tick(); n++; end while (!ack_o[0] && n < 100);
    chk("single_ack_cycle", n, 13);
    chk("single_result", result_o, 32'h40400000);
    chk("single_rst_fsm", core_rst_fsm_o, 1);
    wait_idle("single");
    chk("single_beg_count", beg_cnt - b0, 1);

    // Contention from the reset pointer: order 0,1,2,3.
    do_reset();
    lat_cfg = 2; grant_log.delete(); a0 = ack_cnt;
    for (int k = 0; k < N; k++) issue_rand(k);
    wait_idle("contention");
    chk("contention_acks", ack_cnt - a0, 4);
    for (int i = 0; i < 4; i++) chk("contention_order", (grant_log.size() > i) ? grant_log[i] : -1, i);

    // Fairness: 0 and 2 stay high, 1 joins mid-stream.
    do_reset();
    grant_log.delete();
    issue_rand(0); issue_rand(2); reissue[0] = 4; reissue[2] = 4;
    n = 0;
    while (grant_log.size() < 3 && n < 500) begin tick(); n++; end
    issue_rand(1);
    wait_idle("fair");
    chk("fair_g0", grant_log[0], 0);
    chk("fair_g1", grant_log[1], 2);
    chk("fair_g2", grant_log[2], 0);
    pos1 = -1;
    for (int i = 0; i < grant_log.size(); i++) if (grant_log[i] == 1 && pos1 < 0) pos1 = i;
    chk("fair_req1_within_2", (pos1 >= 3 && pos1 <= 4), 1);

    // Reset in the middle of WAIT.
    lat_cfg = 10;
    issue_rand(3);
    n = 0;
    while (!(busy_o && !core_beg_o) && n < 50) begin tick(); n++; end
    tick();
    a0 = ack_cnt;
    do_reset();
    repeat (6) tick();
    chk("no_ack_after_reset", ack_cnt - a0, 0);
    issue_rand(3);
    wait_idle("after_reset");
    chk("fresh_req_served", ack_cnt - a0, 1);

    // Flags hold until the next capture.
    lat_cfg = 3;
    issue(1, 32'h40000000, 32'h40000000, OP_ADD);
    wait_idle("ovf1");
    repeat (3) tick();
    chk("ovf_holds", ovf_o, 1);
    issue(1, 32'h3F800000, 32'h3F800000, OP_ADD);
    wait_idle("ovf0");
    chk("ovf_cleared", ovf_o, 0);

    // Randomized traffic with ready glitches and operand scrambling.
    lat_cfg = 0; glitch_en = 1; scramble_en = 1;
    for (int k = 0; k < N; k++) rnd_todo[k] = 8;
    wait_idle("random");
    glitch_en = 0; scramble_en = 0;

`ifdef FPU_ARB_TIMEOUT_EN
    core_stall = 1;
    issue_rand(2);
    wait_idle("timeout");
    chk("timeout_result", result_o, 0);
    chk("timeout_flag", timeout_o, 1);
    core_stall = 0; lat_cfg = 3;
    issue_rand(2);
    wait_idle("timeout_clear");
    chk("timeout_cleared", timeout_o, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
